// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants and types (N=1024 as 32 lanes x 32 beats).
package ntt_pkg;

    localparam int unsigned DATA_WIDTH_PER_INPUT = 32;
    localparam int unsigned N                    = 1024;
    localparam int unsigned LANES                = 32;
    localparam int unsigned HALF                 = LANES / 2;
    localparam int unsigned FRAME_BEATS          = 32;
    localparam int unsigned CNT_W                = $clog2(FRAME_BEATS);

    typedef logic [DATA_WIDTH_PER_INPUT-1:0] coeff_t;
    typedef coeff_t [LANES-1:0] beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/pair_exchange_buf.sv
// Beat-pair hold registers and half-lane routing: swaps the upper half of an
// even beat with the lower half of the following odd beat.
module pair_exchange_buf
    import ntt_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  cap_a_i,
    input  logic  emit_i,
    input  beat_t in_beat_i,
    output beat_t out_beat_o
);

    beat_t a_q, a_d;
    beat_t b_q, b_d;
    beat_t out_q, out_d;
    logic  drain_q, drain_d;
    beat_t even_c;
    beat_t odd_c;

    // Even output beat keeps A's lower half, odd keeps the live upper half.
    for (genvar j = 0; j < HALF; j++) begin : g_route
        assign even_c[j]      = a_q[j];
        assign even_c[HALF+j] = in_beat_i[j];
        assign odd_c[j]       = a_q[HALF+j];
        assign odd_c[HALF+j]  = in_beat_i[HALF+j];
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        drain_d = 1'b0;
        if (cap_a_i) begin
            a_d = in_beat_i;
        end
        if (emit_i) begin
            out_d   = even_c;
            b_d     = odd_c;
            drain_d = 1'b1;
        end else if (drain_q) begin
            out_d = b_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            drain_q <= drain_d;
        end
    end

    assign out_beat_o = out_q;

endmodule

// File: rtl/stage_3_time_lane_exchange.sv
// Streaming exchange of lane-index bit 4 with beat-index bit 0; self-inverse,
// fixed 2-cycle latency, framing regenerated on outStart.
module stage_3_time_lane_exchange
    import ntt_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inStart,
    input  logic [DATA_WIDTH_PER_INPUT-1:0]
        inData_0,  inData_1,  inData_2,  inData_3,  inData_4,  inData_5,  inData_6,  inData_7,
        inData_8,  inData_9,  inData_10, inData_11, inData_12, inData_13, inData_14, inData_15,
        inData_16, inData_17, inData_18, inData_19, inData_20, inData_21, inData_22, inData_23,
        inData_24, inData_25, inData_26, inData_27, inData_28, inData_29, inData_30, inData_31,
    output logic outStart,
    output logic [DATA_WIDTH_PER_INPUT-1:0]
        outData_0,  outData_1,  outData_2,  outData_3,  outData_4,  outData_5,  outData_6,  outData_7,
        outData_8,  outData_9,  outData_10, outData_11, outData_12, outData_13, outData_14, outData_15,
        outData_16, outData_17, outData_18, outData_19, outData_20, outData_21, outData_22, outData_23,
        outData_24, outData_25, outData_26, outData_27, outData_28, outData_29, outData_30, outData_31
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_start_q, out_start_d;
    logic [CNT_W-1:0] beat_c;
    logic             active_c;
    logic             cap_a_c;
    logic             emit_c;
    beat_t            in_beat;
    beat_t            out_beat;

    assign in_beat = {inData_31, inData_30, inData_29, inData_28, inData_27, inData_26, inData_25, inData_24,
                      inData_23, inData_22, inData_21, inData_20, inData_19, inData_18, inData_17, inData_16,
                      inData_15, inData_14, inData_13, inData_12, inData_11, inData_10, inData_9,  inData_8,
                      inData_7,  inData_6,  inData_5,  inData_4,  inData_3,  inData_2,  inData_1,  inData_0};

    // inStart always restarts the frame, even mid-frame; a pending even beat in A is abandoned.
    always_comb begin
        state_d     = IDLE;
        cnt_d       = '0;
        out_start_d = 1'b0;
        cap_a_c     = 1'b0;
        emit_c      = 1'b0;
        active_c    = inStart || (state_q == RUN);
        beat_c      = inStart ? '0 : cnt_q;
        if (active_c) begin
            cnt_d       = beat_c + CNT_W'(1);
            state_d     = (beat_c == CNT_W'(FRAME_BEATS - 1)) ? IDLE : RUN;
            cap_a_c     = ~beat_c[0];
            emit_c      = beat_c[0];
            out_start_d = (beat_c == CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_start_q <= out_start_d;
        end
    end

    pair_exchange_buf u_pair_exchange_buf (
        .clk        (clk),
        .rst_n      (rst),
        .cap_a_i    (cap_a_c),
        .emit_i     (emit_c),
        .in_beat_i  (in_beat),
        .out_beat_o (out_beat)
    );

    assign outStart = out_start_q;
    assign {outData_31, outData_30, outData_29, outData_28, outData_27, outData_26, outData_25, outData_24,
            outData_23, outData_22, outData_21, outData_20, outData_19, outData_18, outData_17, outData_16,
            outData_15, outData_14, outData_13, outData_12, outData_11, outData_10, outData_9,  outData_8,
            outData_7,  outData_6,  outData_5,  outData_4,  outData_3,  outData_2,  outData_1,  outData_0} = out_beat;

endmodule
